miyamii_4002_ram: RTL and testbench

- Data-memory responder for the miyamii_4000 CPU RAM interface. It is the slave end of the CPU's ram_addr/ram_we/ram_ce/ram_data_out request path.
- Returns registered read data on ram_data_in and latches the CPU's RAM output port. Provides a synchronised RAM input port.
- Clears its whole array after reset, or on request, before it accepts any access.
- Replaces ad-hoc behavioural RAM in benches and is the synthesizable RAM for the SoC top.

---
 rtl/miyamii_4002_ram.sv | 156 +++++++++++++++
 tb/tb_miyamii_4002_ram.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/miyamii_4002_ram.sv
// Data-memory responder for the miyamii_4000 CPU: cleared 4-bit word array with
// registered read-before-write access, a latched output port and a synchronised input port.
module miyamii_4002_ram #(
    parameter int DEPTH       = 1280,
    parameter int ADDR_W      = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [3:0]        ram_data_out,
    input  logic              ram_we,
    input  logic              ram_ce,
    output logic [3:0]        ram_data_in,
    input  logic [3:0]        ram_port_out,
    input  logic              ram_port_we,
    output logic [3:0]        port_pins,
    input  logic [3:0]        ext_port_in,
    output logic [3:0]        ram_port_in,
    input  logic              clr_req,
    output logic              init_busy,
    output logic              addr_error
);

    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [MEM_AW-1:0] CNT_LAST = MEM_AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [MEM_AW-1:0] r_cnt;
    logic [MEM_AW-1:0] w_cnt_nxt;
    logic [3:0]        r_mem [DEPTH];
    logic [3:0]        r_rd_data;
    logic [3:0]        w_rd_data_nxt;
    logic              r_addr_error;
    logic              w_addr_error_nxt;
    logic              r_init_busy;
    logic [3:0]        r_port_pins;
    logic [3:0]        r_sync [SYNC_STAGES];
    logic              w_in_range;
    logic [MEM_AW-1:0] w_mem_idx;
    logic              w_wr_en;
    logic [MEM_AW-1:0] w_wr_addr;
    logic [3:0]        w_wr_data;

    // Unsigned range check done at 32 bits so no out-of-range address can alias into the array.
    assign w_in_range = (32'(ram_addr) < 32'(DEPTH));
    assign w_mem_idx  = ram_addr[MEM_AW-1:0];

    // Next-state, clear sequencing, single write-port selection and read-data/error update.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_rd_data_nxt    = r_rd_data;
        w_addr_error_nxt = r_addr_error;
        w_wr_en          = 1'b0;
        w_wr_addr        = r_cnt;
        w_wr_data        = 4'h0;
        case (r_state)
            ST_INIT: begin
                w_wr_en       = 1'b1;
                w_rd_data_nxt = 4'h0;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_READY;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + MEM_AW'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    w_state_nxt      = ST_INIT;
                    w_cnt_nxt        = '0;
                    w_rd_data_nxt    = 4'h0;
                    w_addr_error_nxt = 1'b0;
                end else if (ram_ce) begin
                    if (w_in_range) begin
                        w_rd_data_nxt = r_mem[w_mem_idx];
                        w_wr_en       = ram_we;
                        w_wr_addr     = w_mem_idx;
                        w_wr_data     = ram_data_out;
                    end else begin
                        w_rd_data_nxt    = 4'h0;
                        w_addr_error_nxt = 1'b1;
                    end
                end else begin
                    w_rd_data_nxt = r_rd_data;
                end
            end
            default: begin
                w_state_nxt   = ST_INIT;
                w_cnt_nxt     = '0;
                w_rd_data_nxt = 4'h0;
            end
        endcase
    end

    // Control and read-data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_INIT;
            r_cnt        <= '0;
            r_rd_data    <= 4'h0;
            r_addr_error <= 1'b0;
            r_init_busy  <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_rd_data    <= w_rd_data_nxt;
            r_addr_error <= w_addr_error_nxt;
            r_init_busy  <= (w_state_nxt == ST_INIT);
        end
    end

    // Storage array; contents are only meaningful once the clear sweep has finished.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= w_wr_data;
        end
    end

    // Output port latch, independent of the clear state machine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port_pins <= 4'h0;
        end else if (ram_port_we) begin
            r_port_pins <= ram_port_out;
        end
    end

    // Input-port synchroniser chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 4'h0;
            end
        end else begin
            r_sync[0] <= ext_port_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign ram_data_in = r_rd_data;
    assign addr_error  = r_addr_error;
    assign init_busy   = r_init_busy;
    assign port_pins   = r_port_pins;
    assign ram_port_in = r_sync[SYNC_STAGES-1];

endmodule

// File: tb/tb_miyamii_4002_ram.sv
// Directed bench for miyamii_4002_ram: a word-array model feeds a read-data scoreboard queue.
module tb_miyamii_4002_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] ram_addr;
    logic [3:0]  ram_data_out;
    logic        ram_we;
    logic        ram_ce;
    logic [3:0]  ram_data_in;
    logic [3:0]  ram_port_out;
    logic        ram_port_we;
    logic [3:0]  port_pins;
    logic [3:0]  ext_port_in;
    logic [3:0]  ram_port_in;
    logic        clr_req;
    logic        init_busy;
    logic        addr_error;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  model [1280];
    logic [3:0]  sb_q [$];
    logic [3:0]  last_rd;

    miyamii_4002_ram dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ram_addr     (ram_addr),
        .ram_data_out (ram_data_out),
        .ram_we       (ram_we),
        .ram_ce       (ram_ce),
        .ram_data_in  (ram_data_in),
        .ram_port_out (ram_port_out),
        .ram_port_we  (ram_port_we),
        .port_pins    (port_pins),
        .ext_port_in  (ext_port_in),
        .ram_port_in  (ram_port_in),
        .clr_req      (clr_req),
        .init_busy    (init_busy),
        .addr_error   (addr_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One CPU access cycle; the expected read data is queued before the edge and checked after it.
    task automatic access(input string tag, input logic [11:0] a, input logic ce,
                          input logic we, input logic [3:0] d);
        logic [3:0] exp_v;
        ram_addr     = a;
        ram_ce       = ce;
        ram_we       = we;
        ram_data_out = d;
        if (ce) begin
            if (a < 12'd1280) begin
                last_rd = model[a];
                if (we) model[a] = d;
            end else begin
                last_rd = 4'h0;
            end
        end
        sb_q.push_back(last_rd);
        step();
        ram_ce = 1'b0;
        ram_we = 1'b0;
        exp_v  = sb_q.pop_front();
        chk(tag, 32'(ram_data_in), 32'(exp_v));
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (init_busy === 1'b1 && n < 3000) begin
            step();
            n++;
        end
        chk(tag, 32'(n), 32'd1280);
    endtask

    initial begin
        for (int i = 0; i < 1280; i++) model[i] = 4'h0;
        last_rd      = 4'h0;
        rst_n        = 1'b0;
        ram_addr     = 12'h000;
        ram_data_out = 4'h0;
        ram_we       = 1'b0;
        ram_ce       = 1'b0;
        ram_port_out = 4'h0;
        ram_port_we  = 1'b0;
        ext_port_in  = 4'h0;
        clr_req      = 1'b0;
        repeat (3) step();

        chk("rst_rd_data", 32'(ram_data_in), 32'h0);
        chk("rst_addr_err", 32'(addr_error), 32'h0);
        chk("rst_busy", 32'(init_busy), 32'h1);
        chk("rst_port_pins", 32'(port_pins), 32'h0);
        chk("rst_port_in", 32'(ram_port_in), 32'h0);

        // Accesses during the clear are ignored, including out-of-range ones.
        rst_n    = 1'b1;
        ram_ce   = 1'b1;
        ram_addr = 12'h000;
        step();
        chk("init_rd0", 32'(ram_data_in), 32'h0);
        chk("init_err", 32'(addr_error), 32'h0);
        ram_addr     = 12'h500;
        ram_we       = 1'b1;
        ram_data_out = 4'hF;
        step();
        ram_ce = 1'b0;
        ram_we = 1'b0;
        chk("init_oor_err", 32'(addr_error), 32'h0);
        chk("init_oor_rd", 32'(ram_data_in), 32'h0);
        begin
            int n;
            n = 2;
            while (init_busy === 1'b1 && n < 3000) begin
                step();
                n++;
            end
            chk("init_len", 32'(n), 32'd1280);
        end

        access("wr_123", 12'h123, 1'b1, 1'b1, 4'h9);
        access("rd_123", 12'h123, 1'b1, 1'b0, 4'h0);
        access("rd_124", 12'h124, 1'b1, 1'b0, 4'h0);
        access("wr_010", 12'h010, 1'b1, 1'b1, 4'h3);
        access("coll_old", 12'h010, 1'b1, 1'b1, 4'hC);
        access("coll_new", 12'h010, 1'b1, 1'b0, 4'h0);
        access("ce_low_hold", 12'h123, 1'b0, 1'b1, 4'h1);
        access("ce_low_nowr", 12'h123, 1'b1, 1'b0, 4'h0);
        chk("err_clean", 32'(addr_error), 32'h0);

        access("oor_wr", 12'h500, 1'b1, 1'b1, 4'hF);
        chk("oor_err", 32'(addr_error), 32'h1);
        access("no_alias_000", 12'h000, 1'b1, 1'b0, 4'h0);
        access("oor_rd", 12'h500, 1'b1, 1'b0, 4'h0);
        access("last_wr", 12'd1279, 1'b1, 1'b1, 4'h7);
        access("last_rd", 12'd1279, 1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 100; i++) begin
            access("rand_acc", 12'($urandom_range(0, 1279)), 1'b1,
                   1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end
        chk("err_sticky", 32'(addr_error), 32'h1);

        ram_port_out = 4'h6;
        ram_port_we  = 1'b1;
        step();
        ram_port_we = 1'b0;
        chk("port_6", 32'(port_pins), 32'h6);
        ram_port_out = 4'h5;
        ram_port_we  = 1'b1;
        step();
        ram_port_we = 1'b0;
        chk("port_5", 32'(port_pins), 32'h5);

        ext_port_in = 4'hB;
        step();
        chk("sync_1cyc", 32'(ram_port_in), 32'h0);
        step();
        chk("sync_2cyc", 32'(ram_port_in), 32'hB);

        for (int i = 0; i < 16; i++) access("fill_A", 12'(i), 1'b1, 1'b1, 4'hA);

        // A write in the clr_req cycle must be dropped.
        clr_req      = 1'b1;
        ram_ce       = 1'b1;
        ram_we       = 1'b1;
        ram_addr     = 12'h020;
        ram_data_out = 4'h7;
        step();
        clr_req = 1'b0;
        ram_ce  = 1'b0;
        ram_we  = 1'b0;
        for (int i = 0; i < 1280; i++) model[i] = 4'h0;
        last_rd = 4'h0;
        chk("clr_busy", 32'(init_busy), 32'h1);
        chk("clr_err", 32'(addr_error), 32'h0);
        chk("clr_rd", 32'(ram_data_in), 32'h0);
        count_busy("clr_len");
        for (int i = 0; i < 16; i++) access("post_clr", 12'(i), 1'b1, 1'b0, 4'h0);
        access("post_clr_020", 12'h020, 1'b1, 1'b0, 4'h0);
        access("post_clr_last", 12'd1279, 1'b1, 1'b0, 4'h0);
        chk("port_keep", 32'(port_pins), 32'h5);
        chk("sync_keep", 32'(ram_port_in), 32'hB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
